// File: rtl/xor_frame_accum.sv
// xor_frame_accum: accumulates the per-lane XOR of a frame of input beats.
// The block optionally inverts the result and computes per-lane parity.
// It emits one result per frame over a valid/ready handshake.
module xor_frame_accum #(
    parameter int NCH       = 2,
    parameter int W         = 5,
    parameter int FRAME_LEN = 4,
    parameter int CW        = $clog2(FRAME_LEN + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [NCH*W-1:0]  in_data,
    input  logic              in_last,
    input  logic              mode_inv,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [NCH*W-1:0]  out_xor,
    output logic [NCH-1:0]    out_par,
    output logic [CW-1:0]     out_beats,
    output logic [NCH-1:0]    sticky_err
);

    typedef enum logic [0:0] {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [NCH*W-1:0]   acc_q, acc_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [NCH*W-1:0]   out_xor_q, out_xor_d;
    logic [NCH-1:0]     out_par_q, out_par_d;
    logic [CW-1:0]      out_beats_q, out_beats_d;
    logic [NCH-1:0]     sticky_q, sticky_d;

    // Candidate frame result for a closing beat, together with its lane parities.
    logic [NCH*W-1:0]   res;
    logic [NCH-1:0]     res_par;
    logic               accept;
    logic               closing;

    // Form the would-be result and the parity of each lane.
    always_comb begin
        res     = acc_q ^ in_data ^ {(NCH*W){mode_inv}};
        res_par = '0;
        for (int unsigned c = 0; c < NCH; c++) begin
            res_par[c] = ^res[c*W +: W];
        end
    end

    // Next-state logic for the frame FSM, the accumulator and the result registers.
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        out_xor_d   = out_xor_q;
        out_par_d   = out_par_q;
        out_beats_d = out_beats_q;
        sticky_d    = sticky_q;
        accept      = in_valid && (state_q == ACCUM);
        closing     = accept && (in_last || (cnt_q == CW'(FRAME_LEN - 1)));

        unique case (state_q)
            ACCUM: begin
                if (accept) begin
                    if (closing) begin
                        out_xor_d   = res;
                        out_par_d   = res_par;
                        out_beats_d = cnt_q + CW'(1);
                        sticky_d    = sticky_q | res_par;
                        acc_d       = '0;
                        cnt_d       = '0;
                        state_d     = HOLD;
                    end else begin
                        acc_d = acc_q ^ in_data;
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_d = ACCUM;
                end
            end
            default: state_d = ACCUM;
        endcase
    end

    // State and result registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ACCUM;
            acc_q       <= '0;
            cnt_q       <= '0;
            out_xor_q   <= '0;
            out_par_q   <= '0;
            out_beats_q <= '0;
            sticky_q    <= '0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            out_xor_q   <= out_xor_d;
            out_par_q   <= out_par_d;
            out_beats_q <= out_beats_d;
            sticky_q    <= sticky_d;
        end
    end

    assign in_ready   = (state_q == ACCUM);
    assign out_valid  = (state_q == HOLD);
    assign out_xor    = out_xor_q;
    assign out_par    = out_par_q;
    assign out_beats  = out_beats_q;
    assign sticky_err = sticky_q;

endmodule
